// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the image read path: state encoding, default frame
// geometry and delay constants, and width helpers.
package frame_sequencer_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE  = 3'd0,
    STATE_VSYNC = 3'd1,
    STATE_HSYNC = 3'd2,
    STATE_DATA  = 3'd3,
    STATE_DONE  = 3'd4
  } state_e;

  localparam int DEF_IMAGE_WIDTH           = 768;
  localparam int DEF_IMAGE_HEIGHT          = 512;
  localparam int DEF_START_DELAY           = 100;
  localparam int DEF_HORIZONTAL_SYNC_DELAY = 160;
  localparam int DEF_ADDR_WIDTH            = 19;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int width_of(input int n);
    if (n > 1) return $clog2(n);
    else       return 1;
  endfunction

  function automatic int max_of(input int a, input int b);
    if (a > b) return a;
    else       return b;
  endfunction

endpackage

// File: rtl/frame_sequencer_sync_delay_counter.sv
// Loadable down-counter that stops at zero; times both the VSYNC and HSYNC
// phases of the frame sequencer.
module sync_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: load has priority over decrement, saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (srst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/frame_sequencer.sv
// Frame timing and address generator for the image read datapath: VSYNC
// start-up, per-row HSYNC gap, then pixel-pair beats addressed bottom-up.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int IMAGE_WIDTH           = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT          = DEF_IMAGE_HEIGHT,
  parameter int START_DELAY           = DEF_START_DELAY,
  parameter int HORIZONTAL_SYNC_DELAY = DEF_HORIZONTAL_SYNC_DELAY,
  parameter int ADDR_WIDTH            = DEF_ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start_Req,
  input  logic                                  abort_Req,
  input  logic                                  pix_Ready,
  output logic                                  busy,
  output logic                                  vertical_Pulse,
  output logic                                  horizontal_Pulse,
  output logic                                  pix_Valid,
  output logic [ADDR_WIDTH-1:0]                 pix_Addr,
  output logic [width_of(IMAGE_HEIGHT)-1:0]     row_Index,
  output logic [width_of(IMAGE_WIDTH/2)-1:0]    col_Pair,
  output logic                                  frame_Done
);

  localparam int ROW_W = width_of(IMAGE_HEIGHT);
  localparam int COL_W = width_of(IMAGE_WIDTH / 2);
  localparam int CNT_W = width_of(max_of(START_DELAY, HORIZONTAL_SYNC_DELAY));
  localparam logic [ROW_W-1:0]      ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(IMAGE_WIDTH / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] FRAME_BASE = ADDR_WIDTH'((IMAGE_HEIGHT - 1) * IMAGE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(IMAGE_WIDTH);

  state_e                state_r, next_state_s;
  logic [ROW_W-1:0]      row_r, row_next_s;
  logic [COL_W-1:0]      col_r, col_next_s;
  logic [ADDR_WIDTH-1:0] base_r, base_next_s, addr_r, addr_next_s;
  logic                  busy_r, vpulse_r, hpulse_r, done_r;
  logic                  cnt_load_s, cnt_zero_s;
  logic [CNT_W-1:0]      cnt_value_s;

  sync_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk        (clk),
    .rst_n      (reset),
    .srst       (abort_Req),
    .load       (cnt_load_s),
    .load_value (cnt_value_s),
    .zero       (cnt_zero_s)
  );

  // Next-state, counter and row-base update; abort overrides every transition.
  always_comb begin
    next_state_s = state_r;
    row_next_s   = row_r;
    col_next_s   = col_r;
    base_next_s  = base_r;
    cnt_load_s   = 1'b0;
    cnt_value_s  = {CNT_W{1'b0}};
    if (abort_Req) begin
      next_state_s = STATE_IDLE;
      row_next_s   = {ROW_W{1'b0}};
      col_next_s   = {COL_W{1'b0}};
      base_next_s  = {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        STATE_IDLE: begin
          if (start_Req) begin
            next_state_s = STATE_VSYNC;
            cnt_load_s   = 1'b1;
            cnt_value_s  = CNT_W'(START_DELAY - 1);
            base_next_s  = FRAME_BASE;
          end else begin
            next_state_s = STATE_IDLE;
          end
        end
        STATE_VSYNC: begin
          if (cnt_zero_s) begin
            next_state_s = STATE_HSYNC;
            cnt_load_s   = 1'b1;
            cnt_value_s  = CNT_W'(HORIZONTAL_SYNC_DELAY - 1);
          end else begin
            next_state_s = STATE_VSYNC;
          end
        end
        STATE_HSYNC: begin
          if (cnt_zero_s) begin
            next_state_s = STATE_DATA;
            col_next_s   = {COL_W{1'b0}};
          end else begin
            next_state_s = STATE_HSYNC;
          end
        end
        STATE_DATA: begin
          if (!pix_Ready) begin
            next_state_s = STATE_DATA;
          end else if (col_r != COL_LAST) begin
            col_next_s = col_r + COL_W'(1);
          end else if (row_r == ROW_LAST) begin
            next_state_s = STATE_DONE;
          end else begin
            next_state_s = STATE_HSYNC;
            row_next_s   = row_r + ROW_W'(1);
            col_next_s   = {COL_W{1'b0}};
            base_next_s  = base_r - ROW_STEP;
            cnt_load_s   = 1'b1;
            cnt_value_s  = CNT_W'(HORIZONTAL_SYNC_DELAY - 1);
          end
        end
        STATE_DONE: begin
          next_state_s = STATE_IDLE;
          row_next_s   = {ROW_W{1'b0}};
          col_next_s   = {COL_W{1'b0}};
          base_next_s  = {ADDR_WIDTH{1'b0}};
        end
        default: begin
          next_state_s = STATE_IDLE;
          row_next_s   = {ROW_W{1'b0}};
          col_next_s   = {COL_W{1'b0}};
          base_next_s  = {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
    addr_next_s = base_next_s + ADDR_WIDTH'({col_next_s, 1'b0});
  end

  // State, counters and outputs all register from the same next values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= STATE_IDLE;
      row_r    <= {ROW_W{1'b0}};
      col_r    <= {COL_W{1'b0}};
      base_r   <= {ADDR_WIDTH{1'b0}};
      addr_r   <= {ADDR_WIDTH{1'b0}};
      busy_r   <= 1'b0;
      vpulse_r <= 1'b0;
      hpulse_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      row_r    <= row_next_s;
      col_r    <= col_next_s;
      base_r   <= base_next_s;
      addr_r   <= addr_next_s;
      busy_r   <= (next_state_s != STATE_IDLE);
      vpulse_r <= (next_state_s == STATE_VSYNC);
      hpulse_r <= (next_state_s == STATE_DATA);
      done_r   <= (next_state_s == STATE_DONE);
    end
  end

  assign busy             = busy_r;
  assign vertical_Pulse   = vpulse_r;
  assign horizontal_Pulse = hpulse_r;
  assign pix_Valid        = hpulse_r;
  assign pix_Addr         = addr_r;
  assign row_Index        = row_r;
  assign col_Pair         = col_r;
  assign frame_Done       = done_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer on a small 8x4 frame, compared
// against a per-beat address/timing model computed from frame geometry.
module tb_frame_sequencer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int SD    = 3;
  localparam int HS    = 2;
  localparam int AW    = 5;
  localparam int PAIRS = W / 2;
  localparam int NOSTALL_DONE = SD + H * (HS + PAIRS) + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_Req = 1'b0;
  logic abort_Req = 1'b0;
  logic pix_Ready = 1'b1;
  logic busy, vertical_Pulse, horizontal_Pulse, pix_Valid, frame_Done;
  logic [AW-1:0] pix_Addr;
  logic [1:0]    row_Index;
  logic [1:0]    col_Pair;

  int total = 0;
  int bad   = 0;
  int beat_addr_q[$], beat_row_q[$], beat_col_q[$], beat_cyc_q[$], stall_addr_q[$];
  bit busy_log[$], vp_log[$], done_log[$];
  int stall_cycles;

  always #5 clk = ~clk;

  frame_sequencer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD),
    .HORIZONTAL_SYNC_DELAY(HS), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start_Req(start_Req), .abort_Req(abort_Req),
    .pix_Ready(pix_Ready), .busy(busy), .vertical_Pulse(vertical_Pulse),
    .horizontal_Pulse(horizontal_Pulse), .pix_Valid(pix_Valid),
    .pix_Addr(pix_Addr), .row_Index(row_Index), .col_Pair(col_Pair),
    .frame_Done(frame_Done)
  );

  // Reference model: bottom-up bitmap address of beat k and its no-stall cycle.
  function automatic int exp_addr(input int k);
    return (H - 1 - k / PAIRS) * W + 2 * (k % PAIRS);
  endfunction

  function automatic int exp_cycle(input int k);
    return SD + (k / PAIRS + 1) * HS + k + 1;
  endfunction

  function automatic int outs_packed();
    return int'({busy, vertical_Pulse, horizontal_Pulse, pix_Valid, frame_Done,
                 pix_Addr, row_Index, col_Pair});
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts a frame and records per-cycle observations; cycle 1 is VSYNC entry.
  task automatic run_frame(input int n_cycles, input int stall_beat, input int stall_len,
                           input bit rand_ready, input bit hold_start);
    int left;
    bit rdy;
    beat_addr_q.delete(); beat_row_q.delete(); beat_col_q.delete(); beat_cyc_q.delete();
    stall_addr_q.delete(); busy_log.delete(); vp_log.delete(); done_log.delete();
    stall_cycles = 0;
    left = stall_len;
    start_Req = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start_Req = 1'b0;
    for (int cyc = 1; cyc <= n_cycles; cyc++) begin
      rdy = 1'b1;
      if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
      if (pix_Valid && beat_addr_q.size() == stall_beat && left > 0) begin
        rdy = 1'b0;
        left--;
      end
      pix_Ready = rdy;
      @(negedge clk);
      busy_log.push_back(busy);
      vp_log.push_back(vertical_Pulse);
      done_log.push_back(frame_Done);
      if (pix_Valid && pix_Ready) begin
        beat_addr_q.push_back(int'(pix_Addr));
        beat_row_q.push_back(int'(row_Index));
        beat_col_q.push_back(int'(col_Pair));
        beat_cyc_q.push_back(cyc);
      end else if (pix_Valid) begin
        stall_cycles++;
        stall_addr_q.push_back(int'(pix_Addr));
      end
      @(posedge clk);
      #1;
    end
    start_Req = 1'b0;
    pix_Ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      total++;
      if (outs_packed() !== 0) begin
        bad++;
        $display("FAIL reset_held: outputs=%0h expected 0", outs_packed());
      end
    end
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      total++;
      if (outs_packed() !== 0) begin
        bad++;
        $display("FAIL idle_no_start: outputs=%0h expected 0", outs_packed());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int dcount, dcyc;
    run_frame(32, -1, 0, 1'b0, 1'b0);
    total++;
    if (beat_addr_q.size() !== W * H / 2) begin
      bad++;
      $display("FAIL nominal_beats: got %0d expected %0d", beat_addr_q.size(), W * H / 2);
    end
    for (int k = 0; k < beat_addr_q.size(); k++) begin
      total++;
      if (beat_addr_q[k] !== exp_addr(k) || beat_row_q[k] !== k / PAIRS ||
          beat_col_q[k] !== k % PAIRS || beat_cyc_q[k] !== exp_cycle(k)) begin
        bad++;
        $display("FAIL nominal_beat%0d: addr=%0d row=%0d col=%0d cyc=%0d expected addr=%0d row=%0d col=%0d cyc=%0d",
                 k, beat_addr_q[k], beat_row_q[k], beat_col_q[k], beat_cyc_q[k],
                 exp_addr(k), k / PAIRS, k % PAIRS, exp_cycle(k));
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (vp_log[i] !== (i < SD)) begin
        bad++;
        $display("FAIL nominal_vsync_cyc%0d: got %0d expected %0d", i + 1, vp_log[i], (i < SD));
      end
    end
    dcount = 0;
    dcyc = 0;
    for (int i = 0; i < done_log.size(); i++) if (done_log[i]) begin dcount++; dcyc = i + 1; end
    total++;
    if (dcount !== 1 || dcyc !== NOSTALL_DONE) begin
      bad++;
      $display("FAIL nominal_done: count=%0d cycle=%0d expected count=1 cycle=%0d", dcount, dcyc, NOSTALL_DONE);
    end
    total++;
    if (busy_log[NOSTALL_DONE] !== 1'b0) begin
      bad++;
      $display("FAIL nominal_idle_after_done: busy=%0d expected 0", busy_log[NOSTALL_DONE]);
    end
  endtask

  task automatic test_stall();
    int dcount, dcyc;
    run_frame(36, 6, 3, 1'b0, 1'b0);
    total++;
    if (stall_addr_q.size() !== 3) begin
      bad++;
      $display("FAIL stall_len: got %0d expected 3", stall_addr_q.size());
    end
    foreach (stall_addr_q[i]) begin
      total++;
      if (stall_addr_q[i] !== 20) begin
        bad++;
        $display("FAIL stall_hold_addr: got %0d expected 20", stall_addr_q[i]);
      end
    end
    total++;
    if (beat_addr_q.size() !== 16) begin
      bad++;
      $display("FAIL stall_beats: got %0d expected 16", beat_addr_q.size());
    end
    for (int k = 0; k < beat_addr_q.size(); k++) begin
      total++;
      if (beat_addr_q[k] !== exp_addr(k)) begin
        bad++;
        $display("FAIL stall_beat%0d: addr=%0d expected %0d", k, beat_addr_q[k], exp_addr(k));
      end
    end
    dcount = 0;
    dcyc = 0;
    for (int i = 0; i < done_log.size(); i++) if (done_log[i]) begin dcount++; dcyc = i + 1; end
    total++;
    if (dcount !== 1 || dcyc !== NOSTALL_DONE + 3) begin
      bad++;
      $display("FAIL stall_done: count=%0d cycle=%0d expected count=1 cycle=%0d", dcount, dcyc, NOSTALL_DONE + 3);
    end
  endtask

  task automatic test_random_ready();
    int dcount, dcyc;
    for (int it = 0; it < 3; it++) begin
      run_frame(120, -1, 0, 1'b1, 1'b0);
      total++;
      if (beat_addr_q.size() !== 16) begin
        bad++;
        $display("FAIL rand_beats: got %0d expected 16", beat_addr_q.size());
      end
      for (int k = 0; k < beat_addr_q.size(); k++) begin
        total++;
        if (beat_addr_q[k] !== exp_addr(k) || beat_row_q[k] !== k / PAIRS || beat_col_q[k] !== k % PAIRS) begin
          bad++;
          $display("FAIL rand_beat%0d: addr=%0d row=%0d col=%0d expected addr=%0d row=%0d col=%0d",
                   k, beat_addr_q[k], beat_row_q[k], beat_col_q[k], exp_addr(k), k / PAIRS, k % PAIRS);
        end
      end
      dcount = 0;
      dcyc = 0;
      for (int i = 0; i < done_log.size(); i++) if (done_log[i]) begin dcount++; dcyc = i + 1; end
      total++;
      if (dcount !== 1 || dcyc !== NOSTALL_DONE + stall_cycles) begin
        bad++;
        $display("FAIL rand_done: count=%0d cycle=%0d expected count=1 cycle=%0d",
                 dcount, dcyc, NOSTALL_DONE + stall_cycles);
      end
    end
  endtask

  task automatic abort_at(input int cyc, input string tag);
    int dseen;
    start_Req = 1'b1;
    step(1);
    start_Req = 1'b0;
    step(cyc - 1);
    abort_Req = 1'b1;
    step(1);
    abort_Req = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || pix_Valid !== 1'b0 || vertical_Pulse !== 1'b0 ||
        row_Index !== 2'd0 || col_Pair !== 2'd0) begin
      bad++;
      $display("FAIL %s: busy=%0d valid=%0d vsync=%0d row=%0d col=%0d expected all 0",
               tag, busy, pix_Valid, vertical_Pulse, row_Index, col_Pair);
    end
    dseen = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_Done) dseen++;
    end
    total++;
    if (dseen !== 0) begin
      bad++;
      $display("FAIL %s_no_done: frame_Done pulses=%0d expected 0", tag, dseen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    abort_at(16, "abort_hsync_row2");
    for (int it = 0; it < 3; it++) abort_at($urandom_range(1, NOSTALL_DONE - 1), "abort_random");
    run_frame(32, -1, 0, 1'b0, 1'b0);
    total++;
    if (beat_addr_q.size() !== 16 || beat_addr_q[0] !== 24) begin
      bad++;
      $display("FAIL abort_restart: beats=%0d first_addr=%0d expected beats=16 first_addr=24",
               beat_addr_q.size(), (beat_addr_q.size() > 0) ? beat_addr_q[0] : -1);
    end
  endtask

  task automatic test_start_held();
    int dcount;
    run_frame(34, -1, 0, 1'b0, 1'b1);
    dcount = 0;
    foreach (done_log[i]) if (done_log[i]) dcount++;
    total++;
    if (dcount !== 1 || done_log[NOSTALL_DONE - 1] !== 1'b1) begin
      bad++;
      $display("FAIL held_done: count=%0d at_expected=%0d expected count=1 at cycle %0d",
               dcount, done_log[NOSTALL_DONE - 1], NOSTALL_DONE);
    end
    total++;
    if (busy_log[NOSTALL_DONE] !== 1'b0 || vp_log[NOSTALL_DONE] !== 1'b0) begin
      bad++;
      $display("FAIL held_idle_gap: busy=%0d vsync=%0d expected 0 0", busy_log[NOSTALL_DONE], vp_log[NOSTALL_DONE]);
    end
    total++;
    if (vp_log[NOSTALL_DONE + 1] !== 1'b1 || busy_log[NOSTALL_DONE + 1] !== 1'b1) begin
      bad++;
      $display("FAIL held_restart: vsync=%0d busy=%0d expected 1 1",
               vp_log[NOSTALL_DONE + 1], busy_log[NOSTALL_DONE + 1]);
    end
    total++;
    if (beat_addr_q.size() !== 16) begin
      bad++;
      $display("FAIL held_beats: got %0d expected 16", beat_addr_q.size());
    end
    abort_Req = 1'b1;
    step(1);
    abort_Req = 1'b0;
  endtask

  task automatic test_async_reset();
    start_Req = 1'b1;
    step(1);
    start_Req = 1'b0;
    step(12);
    total++;
    if (pix_Valid !== 1'b1) begin
      bad++;
      $display("FAIL areset_precond: valid=%0d expected 1", pix_Valid);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (outs_packed() !== 0) begin
      bad++;
      $display("FAIL areset_immediate: outputs=%0h expected 0", outs_packed());
    end
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (outs_packed() !== 0) begin
      bad++;
      $display("FAIL areset_idle: outputs=%0h expected 0", outs_packed());
    end
    @(posedge clk);
    #1;
    run_frame(32, -1, 0, 1'b0, 1'b0);
    total++;
    if (beat_addr_q.size() !== 16 || done_log[NOSTALL_DONE - 1] !== 1'b1) begin
      bad++;
      $display("FAIL areset_recover: beats=%0d done_at_expected=%0d expected 16 1",
               beat_addr_q.size(), done_log[NOSTALL_DONE - 1]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_random_ready();
    test_abort();
    test_start_held();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Timing and addressing controller for the image read datapath.
- On a start request it sequences one frame: start-up delay with the vertical sync pulse, then per row a horizontal sync gap followed by pixel beats.
- Each beat carries one even/odd pixel pair and the image-memory address of that pair.
- Sits between the top-level test harness and the pixel memory / threshold datapath, and owns all frame counters.

Parameters:
IMAGE_WIDTH, 768, pixels per row; must be even and >= 2
IMAGE_HEIGHT, 512, rows per frame; >= 1
START_DELAY, 100, VSYNC-state cycles after start; >= 1
HORIZONTAL_SYNC_DELAY, 160, HSYNC-state cycles before each row; >= 1
ADDR_WIDTH, 19, pixel-index address width; must satisfy 2^ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_Req  input  1  frame start pulse; sampled only in IDLE
abort_Req  input  1  synchronous abort; returns to IDLE from any state
pix_Ready  input  1  downstream accepts the current beat
busy  output  1  high in every state except IDLE
vertical_Pulse  output  1  high during the VSYNC state
horizontal_Pulse  output  1  high during the DATA state
pix_Valid  output  1  beat valid; equals horizontal_Pulse
pix_Addr  output  ADDR_WIDTH  pixel index of the even pixel; the odd pixel is pix_Addr+1
row_Index  output  clog2(IMAGE_HEIGHT)  current row, 0 = first row emitted
col_Pair  output  clog2(IMAGE_WIDTH/2)  current pixel-pair index in the row
frame_Done  output  1  one-cycle pulse when the frame completes

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; all counters are 0.
- States: IDLE, VSYNC, HSYNC, DATA, DONE. Encoding is 3 bits.
- IDLE:
  - start_Req=1 moves to VSYNC on the next edge and loads the delay counter with START_DELAY-1.
- VSYNC:
  - vertical_Pulse=1.
  - Lasts exactly START_DELAY cycles.
  - At count 0, moves to HSYNC and loads the counter with HORIZONTAL_SYNC_DELAY-1.
- HSYNC:
  - Lasts exactly HORIZONTAL_SYNC_DELAY cycles, then moves to DATA with col_Pair=0.
- DATA:
  - pix_Valid=1.
  - A beat transfers when pix_Valid and pix_Ready are both 1.
  - When pix_Ready=0: pix_Addr, col_Pair and row_Index hold, and pix_Valid stays 1.
  - On a transfer with col_Pair < IMAGE_WIDTH/2-1: col_Pair increments.
  - On a transfer with col_Pair = IMAGE_WIDTH/2-1:
    - If row_Index = IMAGE_HEIGHT-1, move to DONE.
    - Otherwise, increment row_Index, clear col_Pair, and return to HSYNC with the counter reloaded.
- DONE:
  - Lasts one cycle with frame_Done=1.
  - Then moves to IDLE; row_Index and col_Pair are cleared.
- Addressing (bottom-up bitmap storage):
  - pix_Addr = (IMAGE_HEIGHT-1-row_Index)*IMAGE_WIDTH + 2*col_Pair.
  - Registered and updated in the same cycle as the counters, so it always matches row_Index/col_Pair.
  - Implemented with a row-base register: loaded with (IMAGE_HEIGHT-1)*IMAGE_WIDTH at frame start and decremented by IMAGE_WIDTH at each row change. No multiplier.
- Latency with no stalls:
  - First beat comes START_DELAY+HORIZONTAL_SYNC_DELAY cycles after VSYNC entry.
  - frame_Done is asserted in cycle START_DELAY + IMAGE_HEIGHT*(HORIZONTAL_SYNC_DELAY+IMAGE_WIDTH/2) + 1, counting the VSYNC entry cycle as 1.
  - Defaults give 278629.
- Simultaneous events:
  - abort_Req has priority over every transition: the next state is IDLE, counters clear, frame_Done is not pulsed.
  - start_Req outside IDLE is ignored.
  - start_Req in the same cycle as DONE is ignored; a new frame needs start_Req in IDLE.
- Reset asserted mid-frame takes effect immediately.
- There is no pending-start memory.

Decomposition:
- Shared definitions file holds:
  - the state encoding constants (STATE_IDLE..STATE_DONE);
  - default image geometry and delay constants, shared with the data-read block.
- One sub-module: sync_delay_counter.
  - Loadable down-counter with load, value and zero flag.
  - Width is clog2 of max(START_DELAY, HORIZONTAL_SYNC_DELAY).
  - Reused for the VSYNC and HSYNC timing.

Test Plan (parameters W=8, H=4, START_DELAY=3, HSYNC_DELAY=2, unless noted):
1. Reset held, then released with no start.
   -> All outputs 0; state IDLE indefinitely.
2. start_Req pulse, pix_Ready=1 constant.
   -> vertical_Pulse high for cycles 1-3; first beat in cycle 6 with pix_Addr=24, row 0.
   -> Row 0 addresses 24, 26, 28, 30.
   -> Last beat pix_Addr=6.
   -> frame_Done in cycle 28, exactly once.
3. Same as scenario 2 with pix_Ready=0 for 3 cycles at row 1, col_Pair 2.
   -> pix_Addr holds 20 during the stall; no beat is lost or duplicated (16 total).
   -> frame_Done moves to cycle 31.
4. abort_Req in HSYNC of row 2.
   -> IDLE next cycle; busy=0; no frame_Done.
   -> A following start_Req yields a full frame starting at pix_Addr=24.
5. start_Req held high through a frame and DONE.
   -> The second frame begins only after IDLE is reached (VSYNC one cycle after DONE+IDLE).
   -> The frame is not re-entered from DONE.
6. reset driven low mid-DATA, asynchronous to clk.
   -> Outputs 0 before the next edge.
   -> Default parameters: a full frame yields 196608 beats and frame_Done at cycle 278629.
